// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 16x oversampling and a one-entry
// valid/ready output buffer. Flags framing errors and buffer overruns.
module uart_rx #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned ACC_W  = 28
) (
  input  logic       sys_clk_i,
  input  logic       sys_rstn_i,
  input  logic       uart_rx_i,
  output logic [7:0] uart_dat_o,
  output logic       uart_valid_o,
  input  logic       uart_rdy_i,
  output logic       uart_ferr_o,
  output logic       uart_ovr_o
);

  localparam logic [ACC_W-1:0] TICK_INC = ACC_W'(16 * BAUD);
  localparam logic [ACC_W-1:0] TICK_LIM = ACC_W'(CLK_HZ);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } state_t;

  logic             rx_p0;
  logic             rx_p1;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_sum;
  logic             tick;
  state_t           state_q;
  state_t           state_d;
  logic [3:0]       tcnt_q;
  logic [3:0]       tcnt_d;
  logic [2:0]       bcnt_q;
  logic [2:0]       bcnt_d;
  logic [7:0]       shift_q;
  logic [7:0]       shift_d;
  logic             dlv_q;
  logic             dlv_d;
  logic             ferr_d;

  // Stage p0 -> p1: two-flop synchronizer; rx_p1 is the only copy of the line
  // that the receiver logic looks at. Resets to the idle (high) level.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rstn_i) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= uart_rx_i;
      rx_p1 <= rx_p0;
    end
  end

  // Fractional tick generator: one tick per 1/16 bit on average. Free-running,
  // never re-phased on a start edge; the mid-bit sample absorbs the jitter.
  assign acc_sum = acc_q + TICK_INC;
  assign tick    = (acc_sum >= TICK_LIM);

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rstn_i) begin
      acc_q <= '0;
    end else if (tick) begin
      acc_q <= acc_sum - TICK_LIM;
    end else begin
      acc_q <= acc_sum;
    end
  end

  // Frame FSM state, counters, deliver strobe and framing-error pulse.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rstn_i) begin
      state_q     <= IDLE;
      tcnt_q      <= '0;
      bcnt_q      <= '0;
      dlv_q       <= 1'b0;
      uart_ferr_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      bcnt_q      <= bcnt_d;
      dlv_q       <= dlv_d;
      uart_ferr_o <= ferr_d;
    end
  end

  // Assembly register: pure data, only meaningful once a frame completes.
  always_ff @(posedge sys_clk_i) begin
    shift_q <= shift_d;
  end

  // Next-state logic: start bit checked at its centre (8 ticks in), then each
  // following bit sampled 16 ticks after the previous sample point.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    dlv_d   = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_p1) begin
          state_d = START;
          tcnt_d  = '0;
        end
      end
      START: begin
        if (tick) begin
          if (tcnt_q == 4'd7) begin
            if (rx_p1) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              tcnt_d  = '0;
              bcnt_d  = '0;
            end
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tcnt_q == 4'd15) begin
            shift_d[bcnt_q] = rx_p1;
            tcnt_d          = '0;
            if (bcnt_q == 3'd7) begin
              state_d = STOP;
            end else begin
              bcnt_d = bcnt_q + 3'd1;
            end
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tcnt_q == 4'd15) begin
            tcnt_d = '0;
            if (rx_p1) begin
              dlv_d   = 1'b1;
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = WAIT_HI;
            end
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end
      WAIT_HI: begin
        // A held-low line (break) raises one error only; wait for idle.
        if (rx_p1) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // One-entry output buffer. A consumer accept on the deliver cycle frees the
  // slot in time for the new byte, so valid stays high and nothing is lost.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rstn_i) begin
      uart_dat_o   <= '0;
      uart_valid_o <= 1'b0;
      uart_ovr_o   <= 1'b0;
    end else begin
      uart_ovr_o <= 1'b0;
      if (dlv_q) begin
        if (!uart_valid_o || uart_rdy_i) begin
          uart_dat_o   <= shift_q;
          uart_valid_o <= 1'b1;
        end else begin
          uart_ovr_o <= 1'b1;
        end
      end else if (uart_valid_o && uart_rdy_i) begin
        uart_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed tests for uart_rx at 7.3728 MHz / 115200 baud
// (one tick every 4 clocks, one bit every 64 clocks).
module tb_uart_rx;

  localparam int unsigned CLK_HZ = 7_372_800;
  localparam int unsigned BAUD   = 115200;
  localparam int unsigned ACC_W  = 28;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       rx   = 1'b0;
  logic       rdy  = 1'b0;
  logic [7:0] dat;
  logic       valid;
  logic       ferr;
  logic       ovr;

  int n_cmp = 0;
  int n_err = 0;

  // cycles since reset release: equals n just after the n-th active edge
  int cyc = 0;
  // pulse/level counters sampled on the falling edge
  int vhi_cnt  = 0;
  int vlo_cnt  = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  logic [7:0] last_dat = 8'h00;

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ACC_W(ACC_W)) dut (
    .sys_clk_i   (clk),
    .sys_rstn_i  (rstn),
    .uart_rx_i   (rx),
    .uart_dat_o  (dat),
    .uart_valid_o(valid),
    .uart_rdy_i  (rdy),
    .uart_ferr_o (ferr),
    .uart_ovr_o  (ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (valid) begin
        vhi_cnt  <= vhi_cnt + 1;
        last_dat <= dat;
      end else begin
        vlo_cnt <= vlo_cnt + 1;
      end
      if (ferr) ferr_cnt <= ferr_cnt + 1;
      if (ovr)  ovr_cnt  <= ovr_cnt + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start a frame on a tick-aligned cycle (cyc multiple of 4) so that the
  // deliver cycle lands exactly 609 edges after the start edge.
  task automatic align();
    @(posedge clk);
    #1;
    while (cyc % 4 != 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int nstop,
                           input logic stopv, input int low_tail);
    rx = 1'b0;
    idle(64);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(64);
    end
    for (int s = 0; s < nstop; s++) begin
      rx = stopv;
      idle(64);
    end
    if (low_tail > 0) begin
      rx = 1'b0;
      idle(low_tail);
    end
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    rx   = 1'b0;
    rdy  = 1'b0;
    idle(3);
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", valid); end
    n_cmp++; if (dat !== 8'h00) begin n_err++; $display("FAIL rst_dat: got %h want 00", dat); end
    n_cmp++; if (ferr !== 1'b0) begin n_err++; $display("FAIL rst_ferr: got %b want 0", ferr); end
    n_cmp++; if (ovr !== 1'b0) begin n_err++; $display("FAIL rst_ovr: got %b want 0", ovr); end
    rx   = 1'b1;
    rstn = 1'b1;
    idle(100);
    n_cmp++; if (vhi_cnt !== 0) begin n_err++; $display("FAIL rst_idle_valid: got %0d cycles want 0", vhi_cnt); end
    n_cmp++; if (ferr_cnt + ovr_cnt !== 0) begin n_err++; $display("FAIL rst_idle_flags: got %0d want 0", ferr_cnt + ovr_cnt); end
  endtask

  task automatic test_single_byte();
    int v0, f0, o0;
    rdy = 1'b1;
    v0 = vhi_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    align();
    send_bits(8'hA5, 2, 1'b1, 0);
    idle(20);
    n_cmp++; if (vhi_cnt - v0 !== 1) begin n_err++; $display("FAIL a5_valid_len: got %0d want 1", vhi_cnt - v0); end
    n_cmp++; if (last_dat !== 8'hA5) begin n_err++; $display("FAIL a5_dat: got %h want a5", last_dat); end
    n_cmp++; if (dat !== 8'hA5) begin n_err++; $display("FAIL a5_dat_hold: got %h want a5", dat); end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL a5_valid_end: got %b want 0", valid); end
    n_cmp++; if (ferr_cnt - f0 !== 0) begin n_err++; $display("FAIL a5_ferr: got %0d want 0", ferr_cnt - f0); end
    n_cmp++; if (ovr_cnt - o0 !== 0) begin n_err++; $display("FAIL a5_ovr: got %0d want 0", ovr_cnt - o0); end
  endtask

  task automatic test_back_to_back();
    int f0, o0;
    rdy = 1'b0;
    f0 = ferr_cnt; o0 = ovr_cnt;
    align();
    send_bits(8'h00, 1, 1'b1, 0);
    send_bits(8'hFF, 1, 1'b1, 0);
    send_bits(8'h55, 1, 1'b1, 0);
    idle(20);
    n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid: got %b want 1", valid); end
    n_cmp++; if (dat !== 8'h00) begin n_err++; $display("FAIL b2b_dat: got %h want 00", dat); end
    n_cmp++; if (ovr_cnt - o0 !== 2) begin n_err++; $display("FAIL b2b_ovr: got %0d want 2", ovr_cnt - o0); end
    n_cmp++; if (ferr_cnt - f0 !== 0) begin n_err++; $display("FAIL b2b_ferr: got %0d want 0", ferr_cnt - f0); end
  endtask

  task automatic test_accept_on_deliver();
    int l0, o0;
    rdy = 1'b0;
    align();
    l0 = vlo_cnt; o0 = ovr_cnt;
    fork
      send_bits(8'h12, 1, 1'b1, 0);
      begin
        idle(608);
        rdy = 1'b1;
        idle(1);
        rdy = 1'b0;
      end
    join
    idle(20);
    n_cmp++; if (dat !== 8'h12) begin n_err++; $display("FAIL coll_dat: got %h want 12", dat); end
    n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL coll_valid: got %b want 1", valid); end
    n_cmp++; if (vlo_cnt - l0 !== 0) begin n_err++; $display("FAIL coll_valid_gap: got %0d low cycles want 0", vlo_cnt - l0); end
    n_cmp++; if (ovr_cnt - o0 !== 0) begin n_err++; $display("FAIL coll_ovr: got %0d want 0", ovr_cnt - o0); end
  endtask

  task automatic test_accept();
    rdy = 1'b1;
    idle(1);
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL acc_valid: got %b want 0", valid); end
    n_cmp++; if (dat !== 8'h12) begin n_err++; $display("FAIL acc_dat_retain: got %h want 12", dat); end
    idle(10);
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL acc_rdy_idle: got %b want 0", valid); end
  endtask

  task automatic test_framing_error();
    int v0, f0;
    rdy = 1'b1;
    v0 = vhi_cnt; f0 = ferr_cnt;
    align();
    send_bits(8'h3C, 1, 1'b0, 200);
    idle(50);
    n_cmp++; if (ferr_cnt - f0 !== 1) begin n_err++; $display("FAIL ferr_pulse: got %0d want 1", ferr_cnt - f0); end
    n_cmp++; if (vhi_cnt - v0 !== 0) begin n_err++; $display("FAIL ferr_no_valid: got %0d want 0", vhi_cnt - v0); end
    align();
    send_bits(8'h81, 1, 1'b1, 0);
    idle(20);
    n_cmp++; if (vhi_cnt - v0 !== 1) begin n_err++; $display("FAIL ferr_next_valid: got %0d want 1", vhi_cnt - v0); end
    n_cmp++; if (last_dat !== 8'h81) begin n_err++; $display("FAIL ferr_next_dat: got %h want 81", last_dat); end
    n_cmp++; if (ferr_cnt - f0 !== 1) begin n_err++; $display("FAIL ferr_total: got %0d want 1", ferr_cnt - f0); end
  endtask

  task automatic test_glitch();
    int v0, f0;
    rdy = 1'b1;
    v0 = vhi_cnt; f0 = ferr_cnt;
    align();
    rx = 1'b0;
    idle(20);
    rx = 1'b1;
    idle(100);
    n_cmp++; if (vhi_cnt - v0 !== 0) begin n_err++; $display("FAIL glitch_valid: got %0d want 0", vhi_cnt - v0); end
    n_cmp++; if (ferr_cnt - f0 !== 0) begin n_err++; $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt - f0); end
    align();
    send_bits(8'h7E, 1, 1'b1, 0);
    idle(20);
    n_cmp++; if (vhi_cnt - v0 !== 1) begin n_err++; $display("FAIL glitch_next_valid: got %0d want 1", vhi_cnt - v0); end
    n_cmp++; if (last_dat !== 8'h7E) begin n_err++; $display("FAIL glitch_next_dat: got %h want 7e", last_dat); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_accept_on_deliver();
    test_accept();
    test_framing_error();
    test_glitch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
